// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory read port, processor valid/ready port and PC control.
// master = fetch unit side, slave = memory/processor side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              ld_pc;
  logic [ADDR_W-1:0] ld_addr;
  logic              halt;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_rdata, instr_ready, ld_pc, ld_addr, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_rdata, instr_ready, ld_pc, ld_addr, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding fixed-latency memory reads and
// hands words to the processor over valid/ready. Define FETCH_TRACE_EN to add the fetch_count port.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               resetn,
`ifdef FETCH_TRACE_EN
  output logic [15:0]        fetch_count,
`endif
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  wait_cnt;
  logic              issue;
  logic              xfer;

  // resetn is active-high despite its name; a request is never issued in a reset or load cycle.
  assign issue        = (state == FETCH) && !bus.halt && !bus.ld_pc && !resetn;
  assign xfer         = bus.instr_valid && bus.instr_ready;
  assign bus.mem_req  = issue;
  assign bus.mem_addr = issue ? pc : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      wait_cnt        <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
    end else if (bus.ld_pc) begin
      // A load discards any in-flight read or presented word; a same-cycle transfer has already happened.
      state           <= FETCH;
      pc              <= bus.ld_addr;
      bus.instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (issue) begin
            wait_cnt <= CNT_W'(MEM_LAT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            bus.instr       <= bus.mem_rdata;
            bus.instr_pc    <= pc;
            bus.instr_valid <= 1'b1;
            pc              <= pc + ADDR_W'(1);
            state           <= HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            bus.instr_valid <= 1'b0;
            state           <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  // Saturating count of accepted instructions; survives PC loads.
  always_ff @(posedge clock) begin
    if (resetn) begin
      fetch_count <= '0;
    end else if (xfer && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven cycle vectors on a MEM_LAT=1 instance,
// a transfer scoreboard, and a hand-written PC-wrap sequence on a MEM_LAT=3 instance.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus3 ();

`ifdef FETCH_TRACE_EN
  logic [15:0] cnt1;
  logic [15:0] cnt3;
`endif

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1), .RESET_PC(8'h00)) u1 (
    .clock      (clk),
    .resetn     (rst1),
`ifdef FETCH_TRACE_EN
    .fetch_count(cnt1),
`endif
    .bus        (bus1.master)
  );

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3), .RESET_PC(8'h00)) u3 (
    .clock      (clk),
    .resetn     (rst3),
`ifdef FETCH_TRACE_EN
    .fetch_count(cnt3),
`endif
    .bus        (bus3.master)
  );

  // Instruction memory models: data appears MEM_LAT cycles after the request cycle.
  logic [15:0] mem [256];
  logic [15:0] pipe3 [3];

  always @(posedge clk) bus1.mem_rdata <= bus1.mem_req ? mem[bus1.mem_addr] : 16'hDEAD;

  always @(posedge clk) begin
    pipe3[0] <= bus3.mem_req ? mem[bus3.mem_addr] : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_rdata = pipe3[2];

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 16'h1111;
      8'h01:   return 16'h2222;
      8'h02:   return 16'h3333;
      default: return {a, a ^ 8'h5A};
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } xfer_t;

  xfer_t q1[$];
  xfer_t q3[$];

  // Scoreboards: every accepted instruction must match the oldest expected transfer.
  always @(negedge clk) begin
    if (!rst1 && bus1.instr_valid && bus1.instr_ready) begin
      check("u1_xfer_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        xfer_t e;
        e = q1.pop_front();
        check("u1_xfer_pc", 32'(bus1.instr_pc), 32'(e.pc));
        check("u1_xfer_instr", 32'(bus1.instr), 32'(e.instr));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst3 && bus3.instr_valid && bus3.instr_ready) begin
      check("u3_xfer_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        xfer_t e;
        e = q3.pop_front();
        check("u3_xfer_pc", 32'(bus3.instr_pc), 32'(e.pc));
        check("u3_xfer_instr", 32'(bus3.instr), 32'(e.instr));
      end
    end
  end

  typedef struct {
    bit          start;
    bit          rdy;
    bit          hlt;
    bit          ld;
    logic [7:0]  ld_a;
    bit          e_req;
    logic [7:0]  e_addr;
    bit          e_val;
    logic [15:0] e_instr;
    logic [7:0]  e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit start, bit rdy, bit hlt, bit ld, logic [7:0] ld_a,
                             bit e_req, logic [7:0] e_addr, bit e_val,
                             logic [15:0] e_instr, logic [7:0] e_pc, int e_cnt);
    vec_t r;
    r.start = start; r.rdy = rdy; r.hlt = hlt; r.ld = ld; r.ld_a = ld_a;
    r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val;
    r.e_instr = e_instr; r.e_pc = e_pc; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic do_reset();
    rst1 = 1'b1;
    bus1.instr_ready = 1'b0;
    bus1.halt = 1'b0;
    bus1.ld_pc = 1'b0;
    bus1.ld_addr = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mem_req", 32'(bus1.mem_req), 32'd0);
    check("rst_mem_addr", 32'(bus1.mem_addr), 32'd0);
    check("rst_instr_valid", 32'(bus1.instr_valid), 32'd0);
    check("rst_instr", 32'(bus1.instr), 32'd0);
    check("rst_instr_pc", 32'(bus1.instr_pc), 32'd0);
`ifdef FETCH_TRACE_EN
    check("rst_fetch_count", 32'(cnt1), 32'd0);
`endif
    @(posedge clk); #1;
    check("sb_drained", 32'(q1.size()), 32'd0);
    q1.delete();
    rst1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus1.instr_ready = 1'b0; bus1.halt = 1'b0; bus1.ld_pc = 1'b0; bus1.ld_addr = 8'h00;
    bus3.instr_ready = 1'b0; bus3.halt = 1'b0; bus3.ld_pc = 1'b0; bus3.ld_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = mem_word(8'(i));

    //              st rdy hlt ld ld_a   req addr   val instr              pc     cnt
    // Streaming with ready high: one word every 3 cycles.
    tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'h1111, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00,  1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'h2222, 8'h01, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h02, 0, 16'h0000, 8'h00,  2));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'h3333, 8'h02, -1));
    // Back-pressure: ready low for 5 cycles after the first valid.
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 16'h1111, 8'h00, (i == 4) ? 0 : -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'h1111, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00,  1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'h2222, 8'h01, -1));
    // PC load while waiting on address 1: that word is dropped.
    tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'h1111, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 1, 8'h40, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h40, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, mem_word(8'h40), 8'h40, -1));
    // PC load coinciding with the transfer of address 5.
    tbl.push_back(v(1, 1, 0, 1, 8'h05, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h05, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 1, 8'h10, 0, 8'h00, 1, mem_word(8'h05), 8'h05, 0));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h10, 0, 16'h0000, 8'h00,  1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, mem_word(8'h10), 8'h10, -1));
    // Halt in FETCH blocks requests; halt during WAIT lets the pending word through.
    tbl.push_back(v(1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, -1));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 0, 8'h00, 1, 16'h1111, 8'h00, -1));
    tbl.push_back(v(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00,  1));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00, -1));

    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      if (t.start) do_reset();
      bus1.instr_ready = t.rdy;
      bus1.halt        = t.hlt;
      bus1.ld_pc       = t.ld;
      bus1.ld_addr     = t.ld_a;
      if (t.e_val && t.rdy) q1.push_back('{t.e_pc, t.e_instr});
      @(negedge clk);
      check($sformatf("r%0d_mem_req", i), 32'(bus1.mem_req), 32'(t.e_req));
      if (t.e_req) check($sformatf("r%0d_mem_addr", i), 32'(bus1.mem_addr), 32'(t.e_addr));
      check($sformatf("r%0d_instr_valid", i), 32'(bus1.instr_valid), 32'(t.e_val));
      if (t.e_val) begin
        check($sformatf("r%0d_instr", i), 32'(bus1.instr), 32'(t.e_instr));
        check($sformatf("r%0d_instr_pc", i), 32'(bus1.instr_pc), 32'(t.e_pc));
      end
`ifdef FETCH_TRACE_EN
      if (t.e_cnt >= 0) check($sformatf("r%0d_fetch_count", i), 32'(cnt1), 32'(t.e_cnt));
`endif
      @(posedge clk); #1;
    end
    rst1 = 1'b1;
    check("u1_sb_final", 32'(q1.size()), 32'd0);

    // MEM_LAT=3: start at 8'hFF, valid 4 cycles after the request, then wrap to 8'h00.
    bus3.ld_pc = 1'b1; bus3.ld_addr = 8'hFF; bus3.instr_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    q3.push_back('{8'hFF, mem_word(8'hFF)});
    q3.push_back('{8'h00, mem_word(8'h00)});
    @(negedge clk);
    check("u3_ld_cycle_req", 32'(bus3.mem_req), 32'd0);
    @(posedge clk); #1;
    bus3.ld_pc = 1'b0;
    @(negedge clk);
    check("u3_req_ff", 32'(bus3.mem_req), 32'd1);
    check("u3_addr_ff", 32'(bus3.mem_addr), 32'hFF);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end while (!bus3.instr_valid && lat < 10);
    check("u3_latency_ff", 32'(lat), 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("u3_req_wrap", 32'(bus3.mem_req), 32'd1);
    check("u3_addr_wrap", 32'(bus3.mem_addr), 32'h00);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end while (!bus3.instr_valid && lat < 10);
    check("u3_latency_00", 32'(lat), 32'd4);
`ifdef FETCH_TRACE_EN
    @(posedge clk); #1;
    @(negedge clk);
    check("u3_fetch_count", 32'(cnt3), 32'd2);
`endif
    @(posedge clk); #1;
    rst3 = 1'b1;
    check("u3_sb_final", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the 16-bit `processor`. Owns the program counter and issues single-outstanding reads to a fixed-latency instruction memory.
- Presents each fetched word to the processor over a valid/ready handshake.
- Supports PC load for jumps/branches, with flush of the in-flight fetch, and a halt input that stops new fetches.

Parameters:
- ADDR_W, 8, width of PC and memory address
- DATA_W, 16, instruction width (matches processor bus)
- MEM_LAT, 1, cycles from mem_req cycle to mem_rdata sample cycle; legal range ≥1
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  input  1  single clock, rising edge
- resetn  input  1  synchronous reset, active-high (1 = reset asserted), sampled on rising clock
- mem_req  output  1  read strobe to instruction memory, one cycle per fetch
- mem_addr  output  ADDR_W  read address, valid while mem_req=1
- mem_rdata  input  DATA_W  memory data, sampled MEM_LAT cycles after the mem_req cycle
- instr  output  DATA_W  fetched instruction to processor
- instr_pc  output  ADDR_W  address instr was fetched from
- instr_valid  output  1  instr/instr_pc valid
- instr_ready  input  1  processor accepts instr this cycle
- ld_pc  input  1  load PC (jump/branch), one-cycle pulse
- ld_addr  input  ADDR_W  new PC when ld_pc=1
- halt  input  1  suppress issuing new fetches while high

Behaviour:
- Reset (resetn=1 at a rising edge): pc=RESET_PC, state=FETCH, mem_req=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, wait counter=0. Reset has priority over every other input.
- Reset mid-operation: an in-flight read is abandoned. Its data is never captured.
- mem_req and mem_addr are combinational from state/pc/halt/ld_pc. All other outputs are registered.
- Handshake rules:
  - Transfer occurs on a cycle with instr_valid=1 and instr_ready=1.
  - While instr_valid=1 and no transfer, instr and instr_pc hold stable.
  - instr_ready is ignored while instr_valid=0.
- States:
  - FETCH:
    - If halt=0 and ld_pc=0: mem_req=1, mem_addr=pc; counter=MEM_LAT-1; next WAIT.
    - If halt=1: mem_req=0; stay in FETCH.
  - WAIT:
    - counter≠0: decrement.
    - counter=0: capture instr=mem_rdata, instr_pc=pc, instr_valid=1, pc=pc+1 (mod 2^ADDR_W); next HOLD.
  - HOLD: on transfer, instr_valid=0 next cycle; next FETCH.
- Timing with MEM_LAT=1:
  - Cycle n: FETCH, mem_req=1.
  - Cycle n+1: WAIT, data sampled.
  - Cycle n+2: instr_valid=1.
  - With instr_ready held high, one instruction per 3 cycles.
  - General: instr_valid rises MEM_LAT+1 cycles after the mem_req cycle.
- ld_pc (priority below reset, above everything else, in any state):
  - pc=ld_addr, instr_valid=0, state=FETCH next cycle.
  - Any in-flight WAIT is discarded. mem_req is forced 0 in the ld_pc cycle.
  - ld_pc in the same cycle as a transfer: the transfer completes (processor consumed instr), then the load applies.
  - The next fetch address is ld_addr, never the old pc+1.
- halt:
  - Only blocks new requests in FETCH.
  - A fetch already in WAIT completes and its result is presented in HOLD normally.
- PC wrap: pc = 2^ADDR_W-1 increments to 0, no flag.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined:
  - Adds output port fetch_count (16 bits), counting handshake transfers.
  - Cleared to 0 on reset, saturates at 16'hFFFF.
  - Not cleared by ld_pc.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Reset for 2 cycles, memory {0:16'h1111, 1:16'h2222, 2:16'h3333}, instr_ready=1, MEM_LAT=1 -> instr_valid at cycle 2 after reset release with instr=16'h1111, instr_pc=0. Then 16'h2222 and 16'h3333 follow at 3-cycle spacing.
- instr_ready=0 for 5 cycles after first valid -> instr=16'h1111 held, mem_req stays 0. Raising ready then gives 16'h2222 three cycles later.
- ld_pc=1, ld_addr=8'h40 while in WAIT for addr 1 -> word from addr 1 never presented. Next mem_addr=8'h40, then instr_pc=8'h40.
- ld_pc concurrent with transfer of addr 5, ld_addr=8'h10 -> transfer counted (fetch_count +1 with FETCH_TRACE_EN). Next fetch at 8'h10, not 6.
- halt=1 in FETCH for 4 cycles -> mem_req=0 throughout. halt raised during WAIT -> the pending word is still delivered.
- Start at pc=8'hFF via ld_pc, MEM_LAT=3 -> instr_pc=8'hFF presented 4 cycles after mem_req. Next mem_addr=8'h00.
